// File: rtl/ttl_decode_glue_pkg.sv
// Shared constants for the instruction-decode TTL glue block.
// Idle levels and mux select encodings used by the RTL and any consumers.
package ttl_decode_glue_pkg;

    localparam logic [7:0]  DEC_IDLE  = 8'hFF;
    localparam logic [31:0] BUS_IDLE  = 32'h0;
    localparam logic        MUX_SEL_A = 1'b0;
    localparam logic        MUX_SEL_B = 1'b1;

endpackage

// File: rtl/ttl_decode_glue_dec3to8.sv
// 74x138-equivalent 3-to-8 decoder with one active-high and two active-low enables.
// Outputs are active-low; all outputs idle high when any enable is inactive.
module ttl_dec3to8
    import ttl_decode_glue_pkg::*;
(
    input  logic [2:0] sel,
    input  logic       g1,
    input  logic       g2a_n,
    input  logic       g2b_n,
    output logic [7:0] y_n
);

    // NOTE: default assigned first so every path drives y_n and no latch is inferred.
    always_comb begin
        y_n = DEC_IDLE;
        if (g1 && !g2a_n && !g2b_n) begin
            y_n[sel] = 1'b0;
        end
    end

endmodule

// File: rtl/ttl_decode_glue.sv
// Decode-stage glue: 3-to-8 decoder, one-hot bus selector and 2:1 mux, each
// with a combinational output and an enabled pipeline-boundary register copy.
module ttl_decode_glue
    import ttl_decode_glue_pkg::*;
#(
    parameter int N_SRC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            dec_sel,
    input  logic                  dec_g1,
    input  logic                  dec_g2a_n,
    input  logic                  dec_g2b_n,
    output logic [7:0]            dec_y_n,
    input  logic [N_SRC-1:0]      bus_oe_n,
    input  logic [32*N_SRC-1:0]   bus_src,
    output logic [31:0]           bus_out,
    output logic                  bus_conflict,
    input  logic [31:0]           mux_a,
    input  logic [31:0]           mux_b,
    input  logic                  mux_s,
    output logic [31:0]           mux_out,
    input  logic                  reg_en_n,
    output logic [7:0]            dec_y_n_q,
    output logic [31:0]           bus_q,
    output logic [31:0]           mux_q
);

    logic [N_SRC-1:0] oe_act;

    ttl_dec3to8 u_dec (
        .sel   (dec_sel),
        .g1    (dec_g1),
        .g2a_n (dec_g2a_n),
        .g2b_n (dec_g2b_n),
        .y_n   (dec_y_n)
    );

    assign oe_act = ~bus_oe_n;

    // Scan from the top down so the lowest enabled index is the last write and wins.
    always_comb begin
        bus_out = BUS_IDLE;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (oe_act[i]) begin
                bus_out = bus_src[32*i +: 32];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign bus_conflict = |(oe_act & (oe_act - N_SRC'(1)));

    assign mux_out = (mux_s == MUX_SEL_A) ? mux_a : mux_b;

    // NOTE: sequential state uses non-blocking assignments so all three copies update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_y_n_q <= DEC_IDLE;
            bus_q     <= BUS_IDLE;
            mux_q     <= '0;
        end else if (!reg_en_n) begin
            dec_y_n_q <= dec_y_n;
            bus_q     <= bus_out;
            mux_q     <= mux_out;
        end
    end

endmodule

// File: tb/tb_ttl_decode_glue.sv
// Self-checking bench for ttl_decode_glue: a behavioural model checked every
// cycle plus directed vectors with hand-computed literal expectations.
module tb_ttl_decode_glue;

    localparam int N_SRC = 3;

    logic                 clk;
    logic                 rst;
    logic [2:0]           dec_sel;
    logic                 dec_g1;
    logic                 dec_g2a_n;
    logic                 dec_g2b_n;
    logic [7:0]           dec_y_n;
    logic [N_SRC-1:0]     bus_oe_n;
    logic [32*N_SRC-1:0]  bus_src;
    logic [31:0]          bus_out;
    logic                 bus_conflict;
    logic [31:0]          mux_a;
    logic [31:0]          mux_b;
    logic                 mux_s;
    logic [31:0]          mux_out;
    logic                 reg_en_n;
    logic [7:0]           dec_y_n_q;
    logic [31:0]          bus_q;
    logic [31:0]          mux_q;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 0;

    ttl_decode_glue #(.N_SRC(N_SRC)) dut (
        .clk          (clk),
        .rst          (rst),
        .dec_sel      (dec_sel),
        .dec_g1       (dec_g1),
        .dec_g2a_n    (dec_g2a_n),
        .dec_g2b_n    (dec_g2b_n),
        .dec_y_n      (dec_y_n),
        .bus_oe_n     (bus_oe_n),
        .bus_src      (bus_src),
        .bus_out      (bus_out),
        .bus_conflict (bus_conflict),
        .mux_a        (mux_a),
        .mux_b        (mux_b),
        .mux_s        (mux_s),
        .mux_out      (mux_out),
        .reg_en_n     (reg_en_n),
        .dec_y_n_q    (dec_y_n_q),
        .bus_q        (bus_q),
        .mux_q        (mux_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic logic [7:0] m_dec(input logic [2:0] sel, input logic g1,
                                         input logic g2a_n, input logic g2b_n);
        if (g1 && !g2a_n && !g2b_n) return ~(8'd1 << sel);
        return 8'hFF;
    endfunction

    function automatic logic [31:0] m_bus(input logic [N_SRC-1:0] oe_n,
                                          input logic [32*N_SRC-1:0] src);
        logic [31:0] words [N_SRC];
        for (int i = 0; i < N_SRC; i++) words[i] = src[32*i +: 32];
        for (int i = 0; i < N_SRC; i++) if (oe_n[i] == 1'b0) return words[i];
        return 32'h0;
    endfunction

    function automatic logic m_conflict(input logic [N_SRC-1:0] oe_n);
        return $countones(~oe_n) > 1;
    endfunction

    logic [7:0]  m_dec_q;
    logic [31:0] m_bus_q;
    logic [31:0] m_mux_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_dec_q <= 8'hFF;
            m_bus_q <= 32'h0;
            m_mux_q <= 32'h0;
        end else if (reg_en_n == 1'b0) begin
            m_dec_q <= m_dec(dec_sel, dec_g1, dec_g2a_n, dec_g2b_n);
            m_bus_q <= m_bus(bus_oe_n, bus_src);
            m_mux_q <= mux_s ? mux_b : mux_a;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_dec_y_n",    32'(dec_y_n),      32'(m_dec(dec_sel, dec_g1, dec_g2a_n, dec_g2b_n)));
            check("mdl_bus_out",    bus_out,           m_bus(bus_oe_n, bus_src));
            check("mdl_bus_confl",  32'(bus_conflict), 32'(m_conflict(bus_oe_n)));
            check("mdl_mux_out",    mux_out,           mux_s ? mux_b : mux_a);
            check("mdl_dec_y_n_q",  32'(dec_y_n_q),    32'(m_dec_q));
            check("mdl_bus_q",      bus_q,             m_bus_q);
            check("mdl_mux_q",      mux_q,             m_mux_q);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] dec_exp [8];

    initial begin
        dec_exp[0] = 8'hFE; dec_exp[1] = 8'hFD; dec_exp[2] = 8'hFB; dec_exp[3] = 8'hF7;
        dec_exp[4] = 8'hEF; dec_exp[5] = 8'hDF; dec_exp[6] = 8'hBF; dec_exp[7] = 8'h7F;

        rst = 1'b1;
        dec_sel = 3'd0; dec_g1 = 1'b0; dec_g2a_n = 1'b1; dec_g2b_n = 1'b1;
        bus_oe_n = '1;
        bus_src = {32'h00000010, 32'hFFFFF800, 32'h12345000};
        mux_a = 32'h0; mux_b = 32'h0; mux_s = 1'b0;
        reg_en_n = 1'b0;

        step();
        check("rst_dec_y_n_q", 32'(dec_y_n_q), 32'hFF);
        check("rst_bus_q",     bus_q,          32'h0);
        check("rst_mux_q",     mux_q,          32'h0);
        rst = 1'b0;
        reg_en_n = 1'b1;
        cmp_en = 1'b1;

        // Decoder sweep.
        dec_g1 = 1'b1; dec_g2a_n = 1'b0; dec_g2b_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            dec_sel = 3'(i);
            #1;
            check($sformatf("dec_sel%0d", i), 32'(dec_y_n), 32'(dec_exp[i]));
            step();
        end
        dec_sel = 3'd3;
        dec_g1 = 1'b0; #1; check("dec_g1_off",  32'(dec_y_n), 32'hFF); step();
        dec_g1 = 1'b1; dec_g2a_n = 1'b1; #1; check("dec_g2a_off", 32'(dec_y_n), 32'hFF); step();
        dec_g2a_n = 1'b0; dec_g2b_n = 1'b1; #1; check("dec_g2b_off", 32'(dec_y_n), 32'hFF); step();
        dec_g2b_n = 1'b0;

        // Bus select.
        bus_oe_n = 3'b110; #1; check("bus_src0", bus_out, 32'h12345000);
        check("bus_src0_conf", 32'(bus_conflict), 32'h0); step();
        bus_oe_n = 3'b011; #1; check("bus_src2", bus_out, 32'h00000010); step();
        bus_oe_n = 3'b111; #1; check("bus_none", bus_out, 32'h0);
        check("bus_none_conf", 32'(bus_conflict), 32'h0); step();
        bus_oe_n = 3'b100; #1; check("bus_multi", bus_out, 32'h12345000);
        check("bus_multi_conf", 32'(bus_conflict), 32'h1); step();
        bus_oe_n = 3'b001; #1; check("bus_12_multi", bus_out, 32'hFFFFF800);
        check("bus_12_conf", 32'(bus_conflict), 32'h1); step();

        // Mux.
        mux_a = 32'h00001000; mux_b = 32'h0;
        mux_s = 1'b0; #1; check("mux_a", mux_out, 32'h00001000); step();
        mux_s = 1'b1; #1; check("mux_b", mux_out, 32'h0); step();

        // Register load then hold.
        dec_sel = 3'd5; bus_oe_n = 3'b101; mux_b = 32'hDEADBEEF; mux_s = 1'b1;
        reg_en_n = 1'b0;
        step();
        check("ld_dec_y_n_q", 32'(dec_y_n_q), 32'hDF);
        check("ld_bus_q",     bus_q,          32'hFFFFF800);
        check("ld_mux_q",     mux_q,          32'hDEADBEEF);
        reg_en_n = 1'b1;
        dec_sel = 3'd1; bus_oe_n = 3'b011; mux_s = 1'b0; mux_a = 32'h0BADF00D;
        step();
        step();
        check("hold_dec_y_n_q", 32'(dec_y_n_q), 32'hDF);
        check("hold_bus_q",     bus_q,          32'hFFFFF800);
        check("hold_mux_q",     mux_q,          32'hDEADBEEF);

        // Async reset mid-cycle, then held across a load edge.
        #3;
        rst = 1'b1;
        #1;
        check("arst_dec_y_n_q", 32'(dec_y_n_q), 32'hFF);
        check("arst_bus_q",     bus_q,          32'h0);
        check("arst_mux_q",     mux_q,          32'h0);
        check("arst_comb_dec",  32'(dec_y_n),   32'hFD);
        reg_en_n = 1'b0;
        step();
        check("rst_edge_bus_q", bus_q, 32'h0);
        check("rst_edge_mux_q", mux_q, 32'h0);

        // First edge after release loads only when enabled.
        rst = 1'b0;
        reg_en_n = 1'b1;
        step();
        check("post_rst_hold", bus_q, 32'h0);
        reg_en_n = 1'b0;
        step();
        check("post_rst_ld_bus", bus_q, 32'h00000010);
        check("post_rst_ld_mux", mux_q, 32'h0BADF00D);
        check("post_rst_ld_dec", 32'(dec_y_n_q), 32'hFD);
        step();

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
